// File: rtl/instruction_memory_loadable.sv
//------------------------------------------------------------------------------
// Module     : instruction_memory_loadable
// Description: Loadable instruction memory with a LOAD/RUN phase, registered
//              one-cycle fetch, stall hold, and range/alignment fault flagging.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instruction_memory_loadable #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    input  logic                  load_start,
    output logic                  busy,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    input  logic                  fetch_stall,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  fetch_fault
);

    localparam int         c_depth   = 1 << DEPTH_LOG2;
    localparam logic [0:0] c_st_load = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]            r_state;
    logic                  r_valid;
    logic                  r_fault;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    logic                  w_in_load;
    logic                  w_in_run;
    logic                  w_load_wr;
    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_fault;
    logic [DEPTH_LOG2-1:0] w_index;

    assign w_in_load    = (r_state == c_st_load);
    assign w_in_run     = (r_state == c_st_run);
    assign w_load_wr    = w_in_load && load_en;
    assign w_accept     = w_in_run && fetch_req && !fetch_stall && !load_start;
    assign w_index      = fetch_addr[DEPTH_LOG2+1:2];
    assign w_misaligned = |fetch_addr[1:0];
    assign w_fault      = w_misaligned || w_out_of_range;

    // Any address bit above the word index means the fetch misses the array.
    generate
        if (DEPTH_LOG2 + 2 <= 31) begin : g_range_check
            assign w_out_of_range = |fetch_addr[31:DEPTH_LOG2+2];
        end else begin : g_no_range_check
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    // Storage carries no reset so a program survives reset and reload requests.
    always_ff @(posedge clk) begin
        if (w_load_wr) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_load;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_instr <= NOP_WORD;
        end else begin
            case (r_state)
                c_st_load: begin
                    r_valid <= 1'b0;
                    r_fault <= 1'b0;
                    if (load_done) begin
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (load_start) begin
                        r_state <= c_st_load;
                        r_valid <= 1'b0;
                        r_fault <= 1'b0;
                    end else if (w_accept) begin
                        r_valid <= 1'b1;
                        r_fault <= w_fault;
                        r_instr <= w_fault ? NOP_WORD : r_mem[w_index];
                    end else if (!fetch_stall) begin
                        // Idle cycle: drop the flags but keep the last word visible.
                        r_valid <= 1'b0;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_load;
                    r_valid <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = w_in_load;
    assign instr_valid = r_valid;
    assign fetch_fault = r_fault;
    assign instruction = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_instruction_memory_loadable.sv
//------------------------------------------------------------------------------
// Module     : tb_instruction_memory_loadable
// Description: Directed and randomized checks of instruction_memory_loadable.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_memory_loadable;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        load_done;
    logic        load_start;
    logic        busy;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        fetch_fault;

    always #5 clk = ~clk;

    instruction_memory_loadable #(
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (8),
        .NOP_WORD   (32'h00000000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_done   (load_done),
        .load_start  (load_start),
        .busy        (busy),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .fetch_fault (fetch_fault)
    );

    // Reference model: a plain word array plus the expected visible outputs.
    logic [31:0] ref_mem [0:255];
    bit          ref_load;
    logic        exp_valid;
    logic        exp_fault;
    logic [31:0] exp_instr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},  {31'b0, busy},        {31'b0, ref_load});
        chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, exp_valid});
        chk({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, exp_fault});
        chk({tag, ".instr"}, instruction,          exp_instr);
    endtask

    // Predict the effect of the current inputs at the next edge, then check.
    task automatic cycle(input string tag);
        if (ref_load) begin
            if (load_en) ref_mem[load_addr] = load_data;
            exp_valid = 1'b0;
            exp_fault = 1'b0;
            if (load_done) ref_load = 1'b0;
        end else if (load_start) begin
            ref_load  = 1'b1;
            exp_valid = 1'b0;
            exp_fault = 1'b0;
        end else if (!fetch_stall) begin
            if (fetch_req) begin
                exp_valid = 1'b1;
                exp_fault = (fetch_addr % 32'd4 != 0) || (fetch_addr >= 32'd1024);
                exp_instr = exp_fault ? 32'h0 : ref_mem[fetch_addr / 32'd4];
            end else begin
                exp_valid = 1'b0;
                exp_fault = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_idle();
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        load_done   = 1'b0;
        load_start  = 1'b0;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_stall = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input string tag);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        cycle(tag);
        fetch_req  = 1'b0;
    endtask

    // Called at posedge+1: reset rises mid-cycle and is checked before the next edge.
    task automatic async_reset(input string tag);
        #3;
        reset     = 1'b1;
        ref_load  = 1'b1;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        exp_instr = 32'h0;
        #1;
        check_all(tag);
        #2;
        reset = 1'b0;
    endtask

    logic [31:0] prog [0:3];
    int          sel;

    initial begin
        prog[0] = 32'h01512000;
        prog[1] = 32'h20080005;
        prog[2] = 32'h00000000;
        prog[3] = 32'hAC080004;

        set_idle();
        reset     = 1'b1;
        ref_load  = 1'b1;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        exp_instr = 32'h0;
        #12;
        check_all("reset_state");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Load program while a fetch request is held: it must be ignored.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = prog[i];
            cycle("load_word");
        end
        load_en   = 1'b0;
        fetch_req = 1'b0;
        load_done = 1'b1;
        cycle("load_done");
        load_done = 1'b0;

        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4), "fetch_b2b");
            if (i < 3) fetch_req = 1'b1;
        end
        cycle("idle_after_b2b");

        // Writes in RUN are dropped.
        load_en   = 1'b1;
        load_addr = 8'h00;
        load_data = 32'hFFFFFFFF;
        cycle("run_write_ignored");
        load_en = 1'b0;
        fetch(32'h0, "fetch_after_run_write");

        fetch(32'h00000402, "misaligned");
        fetch(32'h00000400, "out_of_range");
        fetch(32'h000003FC, "last_word");
        fetch(32'h00000004, "fault_clears");

        // Stall holds the word from address 4 while the address moves to 8.
        fetch(32'h00000004, "pre_stall");
        fetch_req   = 1'b1;
        fetch_addr  = 32'h00000008;
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle("stall_hold");
        fetch_stall = 1'b0;
        cycle("stall_release");
        fetch_req = 1'b0;

        fetch_req  = 1'b1;
        fetch_addr = 32'h0000000C;
        cycle("pre_reset_fetch");
        async_reset("async_reset");
        set_idle();
        load_done = 1'b1;
        cycle("reload_skip");
        load_done = 1'b0;
        fetch(32'h0, "survives_reset");

        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        cycle("load_start_priority");
        set_idle();

        // Fill the whole array with random words, then random traffic.
        for (int i = 0; i < 256; i++) begin
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = $urandom;
            fetch_req = 1'($urandom_range(0, 1));
            cycle("rand_fill");
        end
        set_idle();
        load_done = 1'b1;
        cycle("rand_fill_done");

        for (int i = 0; i < 400; i++) begin
            fetch_req   = ($urandom_range(0, 3) != 0);
            fetch_stall = ($urandom_range(0, 4) == 0);
            load_start  = ($urandom_range(0, 30) == 0);
            load_done   = ($urandom_range(0, 5) == 0);
            load_en     = 1'($urandom_range(0, 1));
            load_addr   = 8'($urandom);
            load_data   = $urandom;
            sel         = $urandom_range(0, 9);
            if (sel < 7)       fetch_addr = $urandom_range(0, 255) * 4;
            else if (sel == 7) fetch_addr = $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
            else if (sel == 8) fetch_addr = $urandom | 32'h00000400;
            else               fetch_addr = $urandom_range(0, 1) ? 32'h000003FC : 32'h00000400;
            cycle("rand_run");
        end
        set_idle();
        cycle("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
